// File: rtl/mem_port_rr_scheduler.sv
// ============================================================================
// Module   : mem_port_rr_scheduler
// Purpose  : Round-robin sharing of one single-outstanding memory port among
//            USER requesters (req/gnt command, rsp_valid response).
// Options  : MEM_PORT_LOCK_EN adds req_lock to keep ownership across commands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_rr_scheduler #(
  parameter int USER      = 4,
  parameter int USER_LOG2 = $clog2(USER),
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic [USER-1:0]        req,
  input  logic [USER-1:0]        req_we,
  input  logic [USER*ADDR_W-1:0] req_addr,
  input  logic [USER*DATA_W-1:0] req_wdata,
`ifdef MEM_PORT_LOCK_EN
  input  logic [USER-1:0]        req_lock,
`endif
  output logic [USER-1:0]        req_gnt,
  output logic [USER-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ready,
  input  logic                   mem_rvalid,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   busy,
  output logic [USER_LOG2-1:0]   owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [USER-1:0] C_ONE = USER'(1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_do_grant;
  logic                   w_do_rsp;
  logic                   w_found;
  logic [USER_LOG2-1:0]   w_pick;
  logic [USER_LOG2-1:0]   w_idx;
  logic                   w_grant_vld;
  logic [USER_LOG2-1:0]   w_grant_idx;

  logic [USER-1:0]        r_gnt;
  logic [USER-1:0]        r_rsp;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_we;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [USER_LOG2-1:0]   r_owner;
  logic [USER_LOG2-1:0]   r_last;

  logic [ADDR_W-1:0]      w_addr  [USER];
  logic [DATA_W-1:0]      w_wdata [USER];

  for (genvar gi = 0; gi < USER; gi++) begin : g_unpack
    assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  // Search starts one past the last winner and wraps at USER-1.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= USER; k++) begin
      w_idx = USER_LOG2'((int'(r_last) + k) % USER);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

`ifdef MEM_PORT_LOCK_EN
  logic r_lock;

  always_comb begin
    w_grant_vld = w_found;
    w_grant_idx = w_pick;
    if (r_lock) begin
      w_grant_vld = req[r_owner];
      w_grant_idx = r_owner;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_lock <= 1'b0;
    end else if (w_do_rsp) begin
      r_lock <= req_lock[r_owner];
    end else if (r_state == S_IDLE && r_lock && !req[r_owner]) begin
      r_lock <= 1'b0;
    end
  end
`else
  always_comb begin
    w_grant_vld = w_found;
    w_grant_idx = w_pick;
  end
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_grant  = 1'b0;
    w_do_rsp    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld) begin
          w_do_grant  = 1'b1;
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        if (mem_ready) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          w_do_rsp    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_gnt   <= '0;
      r_rsp   <= '0;
      r_rdata <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_owner <= '0;
      r_last  <= USER_LOG2'(USER - 1);
    end else begin
      r_gnt <= '0;
      r_rsp <= '0;
      if (w_do_grant) begin
        r_we    <= req_we[w_grant_idx];
        r_addr  <= w_addr[w_grant_idx];
        r_wdata <= w_wdata[w_grant_idx];
        r_owner <= w_grant_idx;
        r_last  <= w_grant_idx;
        r_gnt   <= C_ONE << w_grant_idx;
      end
      if (w_do_rsp) begin
        r_rdata <= mem_rdata;
        r_rsp   <= C_ONE << r_owner;
      end
    end
  end

  assign req_gnt   = r_gnt;
  assign rsp_valid = r_rsp;
  assign rsp_rdata = r_rdata;
  assign mem_req   = (r_state == S_CMD);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_rr_scheduler.sv
// Bench for mem_port_rr_scheduler: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
`default_nettype none

module tb_mem_port_rr_scheduler;

  localparam int U = 4;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_we = '0;
  logic [31:0] a_addr [U];
  logic [31:0] a_wdata[U];
  logic [127:0] req_addr, req_wdata;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  req_gnt, rsp_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_we, busy;
  logic [1:0]  owner;
`ifdef MEM_PORT_LOCK_EN
  logic [3:0]  req_lock = '0;
`endif

  assign req_addr  = {a_addr[3], a_addr[2], a_addr[1], a_addr[0]};
  assign req_wdata = {a_wdata[3], a_wdata[2], a_wdata[1], a_wdata[0]};

  mem_port_rr_scheduler #(.USER(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RSTN(RSTN), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_PORT_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_gnt(req_gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: transaction phase 0=waiting for a winner, 1=command
  // offered to memory, 2=awaiting completion.
  int          m_ph, m_last, m_owner;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_gnt, m_rsp;
  logic [3:0]  pend;

  function automatic int rr_pick(logic [3:0] r, int last);
    for (int k = 1; k <= U; k++)
      if (r[(last + k) % U]) return (last + k) % U;
    return -1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_last = U - 1; m_owner = 0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_gnt = '0; m_rsp = '0;
  endtask

  task automatic model_step();
    int w;
    m_gnt = '0;
    m_rsp = '0;
    case (m_ph)
      0: begin
        w = rr_pick(req, m_last);
        if (w >= 0) begin
          m_we = req_we[w]; m_addr = a_addr[w]; m_wdata = a_wdata[w];
          m_owner = w; m_last = w; m_gnt[w] = 1'b1; m_ph = 1;
        end
      end
      1: if (mem_ready) m_ph = 2;
      default: if (mem_rvalid) begin
        m_rdata = mem_rdata; m_rsp[m_owner] = 1'b1; m_ph = 0;
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("req_gnt",   64'(req_gnt),   64'(m_gnt));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
    chk("mem_req",   64'(mem_req),   64'(m_ph == 1));
    chk("mem_we",    64'(mem_we),    64'(m_we));
    chk("mem_addr",  64'(mem_addr),  64'(m_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    chk("busy",      64'(busy),      64'(m_ph != 0));
    chk("owner",     64'(owner),     64'(m_owner));
    chk("onehot",    64'($countones(req_gnt) <= 1 && $countones(rsp_valid) <= 1), 64'd1);
  endtask

  task automatic tick();
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    req = '0; req_we = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; pend = '0;
    model_reset();
    #1;
    compare_all();
    @(negedge CLK);
    RSTN = 1'b1;
  endtask

  initial begin
    int order[8];
    int n;
    for (int i = 0; i < U; i++) begin a_addr[i] = '0; a_wdata[i] = '0; end
    do_reset();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_owner", 64'(owner), 64'd0);

    // Single read from user 2
    a_addr[2] = 32'h100; req_we[2] = 1'b0; req = 4'b0100; mem_ready = 1'b1;
    tick();
    chk("single_gnt", 64'(req_gnt), 64'h4);
    chk("single_addr", 64'(mem_addr), 64'h100);
    chk("single_we", 64'(mem_we), 64'd0);
    req = '0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("single_rsp", 64'(rsp_valid), 64'h4);
    chk("single_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("single_idle", 64'(busy), 64'd0);
    mem_rvalid = 1'b0;

    // Fairness with all four requesting continuously
    do_reset();
    req = 4'b1111; mem_ready = 1'b1; mem_rvalid = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      mem_rdata = $urandom;
      tick();
      for (int i = 0; i < U; i++)
        if (req_gnt[i] && n < 8) begin order[n] = i; n++; end
    end
    chk("fair_count", 64'(n), 64'd8);
    for (int k = 0; k < 8; k++) chk("fair_order", 64'(order[k]), 64'(k % U));

    // Backpressure on a write from user 1
    do_reset();
    req_we[1] = 1'b1; a_addr[1] = 32'hA5A50004; a_wdata[1] = 32'h12345678;
    req = 4'b0010; mem_ready = 1'b0; mem_rvalid = 1'b0;
    tick();
    chk("bp_gnt", 64'(req_gnt), 64'h2);
    a_addr[1] = 32'hFFFF0000; a_wdata[1] = 32'h0; req_we[1] = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_req", 64'(mem_req), 64'd1);
      chk("bp_addr", 64'(mem_addr), 64'hA5A50004);
      chk("bp_wdata", 64'(mem_wdata), 64'h12345678);
      chk("bp_we", 64'(mem_we), 64'd1);
      chk("bp_nognt", 64'(req_gnt), 64'd0);
    end
    mem_ready = 1'b1;
    tick();
    chk("bp_dropreq", 64'(mem_req), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD;
    tick();
    chk("bp_rsp", 64'(rsp_valid), 64'h2);
    mem_rvalid = 1'b0;
    tick();
    chk("bp_next", 64'(req_gnt), 64'h4);

    // Wrap skip: last=2, requests from 0 and 1
    do_reset();
    req = 4'b0100; mem_ready = 1'b1;
    tick(); req = '0; tick();
    mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
    req = 4'b0011;
    tick();
    chk("wrap_first", 64'(req_gnt), 64'h1);
    req = 4'b0010;
    tick(); mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
    tick();
    chk("wrap_second", 64'(req_gnt), 64'h2);

    // Reset while waiting for the response
    do_reset();
    req = 4'b0001; mem_ready = 1'b1;
    tick(); req = '0; tick(); tick();
    chk("mid_busy", 64'(busy), 64'd1);
    do_reset();
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_memreq", 64'(mem_req), 64'd0);
    req = 4'b1000;
    tick();
    chk("mid_after_gnt", 64'(req_gnt), 64'h8);

    // Random traffic with spurious rvalid and early request drops
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < U; i++) begin
        if (m_gnt[i]) pend[i] = 1'b0;
        if (!pend[i] && ($urandom % 4) == 0) begin
          pend[i] = 1'b1;
          req_we[i] = 1'($urandom);
          a_addr[i] = $urandom;
          a_wdata[i] = $urandom;
        end else if (pend[i] && m_ph == 0 && ($urandom % 32) == 0) begin
          pend[i] = 1'b0;
        end
      end
      req = pend;
      mem_ready  = (($urandom % 3) != 0);
      mem_rvalid = (($urandom % 3) == 0);
      mem_rdata  = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_rr_scheduler.md
Name: mem_port_rr_scheduler

Overview:
- Shares one single-outstanding memory port between USER requesters, e.g. instruction fetch, load/store and debug, on a req/gnt + rsp handshake.
- Uses a registered round-robin FSM that captures the winner's command, issues it to memory, waits for the response and routes it back to the winner.
- Sits between the core's master ports and the on-chip memory/bus bridge.

Parameters:
- USER, 4, number of requesters (≥2, need not be a power of 2)
- USER_LOG2, $clog2(USER), owner index width
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- req  in  USER  per-requester command request
- req_we  in  USER  1 = write, 0 = read
- req_addr  in  USER*ADDR_W  packed addresses; user i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  USER*DATA_W  packed write data
- req_gnt  out  USER  one-cycle pulse: command captured
- rsp_valid  out  USER  one-cycle pulse: response for that user
- rsp_rdata  out  DATA_W  registered read data, broadcast to all users
- mem_req  out  1  command valid to memory
- mem_we  out  1  command type
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  command write data
- mem_ready  in  1  memory accepts command when mem_req && mem_ready
- mem_rvalid  in  1  completion for reads and writes
- mem_rdata  in  DATA_W  read data, valid with mem_rvalid
- busy  out  1  state != IDLE
- owner  out  USER_LOG2  index of current/last winner

Behaviour:
- Reset (async, RSTN=0): state IDLE; all outputs 0; rr pointer last = USER-1, so user 0 wins first; command registers 0.
- FSM states: IDLE, CMD, RESP.
- IDLE:
  - If |req, pick the first set req[i], searching from (last+1) and wrapping at USER-1 to 0.
  - At the clock edge: capture req_we[i]/req_addr[i]/req_wdata[i] into the command registers; owner <= i; last <= i; pulse req_gnt[i] for exactly that cycle; go to CMD.
  - No req: stay in IDLE with no change.
- CMD:
  - mem_req=1; mem_we/mem_addr/mem_wdata come from the registers and are held stable until accepted.
  - When mem_ready=1: go to RESP; mem_req drops the next cycle.
- RESP:
  - mem_req=0.
  - When mem_rvalid=1: rsp_rdata <= mem_rdata; rsp_valid[owner] pulses one cycle (registered, i.e. the cycle after mem_rvalid); go to IDLE.
  - mem_rvalid is sampled only in RESP. The memory must return rvalid ≥1 cycle after accept; rvalid in other states is ignored.
- Minimum period: 4 cycles per transaction (grant, cmd accept, rvalid, rsp). The new arbitration may happen in the same cycle as the rsp_valid pulse.
- Requests in CMD/RESP are not considered. A requester holds req until req_gnt and may drop or change payload after gnt. Dropping req before gnt simply removes it from arbitration.
- At most one req_gnt bit and one rsp_valid bit are high in any cycle.
- Fairness: with all USER requesting continuously, the grant order is 0,1,…,USER-1,0,…
- Writes: rsp_valid is still pulsed and rsp_rdata is updated with mem_rdata (don't-care for the requester).
- Reset mid-transaction: aborts immediately to the reset state; no rsp_valid is issued for the aborted command.

Optional Feature:
- Macro: MEM_PORT_LOCK_EN.
- Defined: adds port req_lock in USER.
  - req_lock[owner] is sampled in the mem_rvalid cycle. If 1, a lock flag is set, and the next IDLE arbitration considers only req[owner]; other requests wait.
  - If the owner has no req in IDLE while locked, the lock clears and normal round-robin resumes the next cycle.
  - The lock flag resets to 0.
- Undefined: no req_lock port; the pointer always rotates.

Test Plan:
- Reset → single request: release RSTN; req=4'b0100 read addr 0x100; mem_ready=1 immediately; mem_rvalid one cycle later with rdata 0xDEADBEEF → req_gnt=4'b0100 one cycle; mem_addr=0x100, mem_we=0; rsp_valid=4'b0100 with rsp_rdata=0xDEADBEEF; busy back to 0.
- Round-robin fairness: req=4'b1111 held, each user re-requesting after its gnt, for 8 transactions → grant order 0,1,2,3,0,1,2,3; never two gnt bits high.
- Backpressure: mem_ready low for 5 cycles in CMD → mem_req stays 1; addr/wdata/we stable for all 6 cycles; no new gnt during that time.
- Wrap skip: last=2, req=4'b0011 → user 0 wins; then user 1 wins.
- Reset mid-RESP: assert RSTN=0 while waiting for rvalid → all outputs 0 at once; after release with req=4'b1000 → user 0-first search gives gnt to user 3.
- MEM_PORT_LOCK_EN: user 1 write with req_lock[1]=1 while req=4'b0111 → user 1 is granted again; then req_lock[1]=0 → user 2 is granted next.
